// File: rtl/vga_shadow_regs.sv
// Double-buffered VGA register bank: Avalon writes land in staging and commit to live outputs at vblank start.
// Optional macro VGA_SHADOW_IRQ_EN builds the vblank interrupt flop; otherwise irq is tied low.
module vga_shadow_regs #(
  parameter int VACTIVE = 480,
  parameter int SCORE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [9:0]  vcount,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] x1,
  output logic [15:0] y1,
  output logic [15:0] x2,
  output logic [15:0] y2,
  output logic [15:0] x3,
  output logic [15:0] y3,
  output logic [15:0] x4,
  output logic [15:0] y4,
  output logic [15:0] x5,
  output logic [15:0] y5,
  output logic [1:0]  state,
  output logic [2:0]  level,
  output logic        result,
  output logic [2:0]  nin_life,
  output logic [3:0]  one,
  output logic [3:0]  ten,
  output logic [3:0]  hun,
  output logic        irq
);

  localparam int CW = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_DONE} bcd_state_t;

  logic [15:0]        stg_xy [12];
  logic [15:0]        live_xy [12];
  logic [1:0]         stg_state;
  logic [2:0]         stg_level;
  logic               stg_result;
  logic [SCORE_W-1:0] stg_score;
  logic [2:0]         stg_life;
  logic [SCORE_W-1:0] live_score;
  logic               dirty;
  logic [7:0]         frame_cnt;
  logic               vge_q;
  logic               vge_prev;
  logic               vbs;
  logic               wr_en;
  logic               wr_ctrl;
  logic [15:0]        rd_mux;

  bcd_state_t         bcd_state;
  bcd_state_t         bcd_next;
  logic               bcd_start;
  logic               bcd_busy;
  logic [11:0]        bcd_sr;
  logic [SCORE_W-1:0] bin_sr;
  logic [CW-1:0]      bcd_cnt;

  function automatic logic [15:0] xy_reset(input int i);
    case (i)
      0:       return 16'd300;
      1:       return 16'd200;
      2:       return 16'd10;
      4:       return 16'd70;
      6:       return 16'd200;
      8:       return 16'd300;
      10:      return 16'd500;
      default: return 16'd300;
    endcase
  endfunction

  function automatic logic [11:0] dabble(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    for (int k = 0; k < 3; k++) begin
      if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // vbs is the rising edge of a registered compare, so it trails vcount reaching VACTIVE by one cycle.
  assign vbs     = vge_q && !vge_prev;
  assign wr_en   = chipselect && write;
  assign wr_ctrl = wr_en && (address == 4'd15);
  assign bcd_busy = (bcd_state != BCD_IDLE) || bcd_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 12; i++) begin
        stg_xy[i]  <= xy_reset(i);
        live_xy[i] <= xy_reset(i);
      end
      stg_state  <= '0;
      stg_level  <= '0;
      stg_result <= 1'b0;
      stg_score  <= '0;
      stg_life   <= '0;
      state      <= '0;
      level      <= '0;
      result     <= 1'b0;
      nin_life   <= '0;
      live_score <= '0;
      dirty      <= 1'b0;
      frame_cnt  <= '0;
      vge_q      <= 1'b1;
      vge_prev   <= 1'b1;
      bcd_start  <= 1'b0;
      readdata   <= '0;
    end else begin
      vge_q     <= (vcount >= 10'(VACTIVE));
      vge_prev  <= vge_q;
      bcd_start <= vbs && dirty && (stg_score != live_score);
      if (vbs) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (dirty) begin
          for (int i = 0; i < 12; i++) live_xy[i] <= stg_xy[i];
          state      <= stg_state;
          level      <= stg_level;
          result     <= stg_result;
          nin_life   <= stg_life;
          live_score <= stg_score;
          dirty      <= 1'b0;
        end
      end
      // A write on the vbs cycle lands after the commit and keeps dirty set for the next frame.
      if (wr_en && address != 4'd15) begin
        dirty <= 1'b1;
        case (address)
          4'd12: begin
            stg_state  <= writedata[1:0];
            stg_level  <= writedata[4:2];
            stg_result <= writedata[5];
          end
          4'd13:   stg_score <= writedata[SCORE_W-1:0];
          4'd14:   stg_life  <= writedata[2:0];
          default: stg_xy[address] <= writedata;
        endcase
      end
      if (wr_ctrl && writedata[1]) dirty <= 1'b0;
      if (chipselect && read) readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd12:   rd_mux = {10'd0, stg_result, stg_level, stg_state};
      4'd13:   rd_mux = 16'(stg_score);
      4'd14:   rd_mux = {13'd0, stg_life};
      4'd15:   rd_mux = {frame_cnt, 4'd0, bcd_busy, dirty, 1'b0, irq};
      default: rd_mux = stg_xy[address];
    endcase
  end

`ifdef VGA_SHADOW_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          irq_q <= 1'b0;
    else if (vbs)                       irq_q <= 1'b1;
    else if (wr_ctrl && writedata[0])   irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcd_state <= BCD_IDLE;
    else       bcd_state <= bcd_next;
  end

  // A start in any state restarts the conversion from iteration 0.
  always_comb begin
    bcd_next = bcd_state;
    if (bcd_start) begin
      bcd_next = BCD_SHIFT;
    end else begin
      case (bcd_state)
        BCD_SHIFT: if (bcd_cnt == CW'(SCORE_W - 1)) bcd_next = BCD_DONE;
        BCD_DONE:  bcd_next = BCD_IDLE;
        default:   bcd_next = BCD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_sr  <= '0;
      bin_sr  <= '0;
      bcd_cnt <= '0;
      one     <= '0;
      ten     <= '0;
      hun     <= '0;
    end else if (bcd_start) begin
      bcd_sr  <= '0;
      bin_sr  <= live_score;
      bcd_cnt <= '0;
    end else if (bcd_state == BCD_SHIFT) begin
      {bcd_sr, bin_sr} <= {dabble(bcd_sr)[10:0], bin_sr, 1'b0};
      bcd_cnt          <= bcd_cnt + 1'b1;
    end else if (bcd_state == BCD_DONE) begin
      {hun, ten, one} <= bcd_sr;
    end
  end

  assign x  = live_xy[0];
  assign y  = live_xy[1];
  assign x1 = live_xy[2];
  assign y1 = live_xy[3];
  assign x2 = live_xy[4];
  assign y2 = live_xy[5];
  assign x3 = live_xy[6];
  assign y3 = live_xy[7];
  assign x4 = live_xy[8];
  assign y4 = live_xy[9];
  assign x5 = live_xy[10];
  assign y5 = live_xy[11];

endmodule

// File: doc/vga_shadow_regs.md
# vga_shadow_regs

Double-buffered register bank between the Avalon slave port and the sprite/RGB controller of the VGA peripheral. Software writes sprite coordinates, screen/level/result, score and lives into staging registers. The whole set is committed atomically to the live outputs at the start of vertical blank, so no frame ever shows a half-updated sprite set. The block also converts the committed score to BCD sequentially, counts frames, and raises a vblank interrupt.

## Interface
Parameters:
- VACTIVE, 480: number of active lines; vblank begins when vcount reaches this value.
- SCORE_W, 8: score width; also the BCD iteration count.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  4  register index.
- writedata  in  16  write data.
- readdata  out  16  read data, 1-cycle latency.
- vcount  in  10  current line from the VGA timing generator.
- x, y, x1, y1, x2, y2, x3, y3, x4, y4, x5, y5  out  16 each  live sprite coordinates.
- state  out  2  live screen select.
- level  out  3  live level, one-hot.
- result  out  1  live pass/fail.
- nin_life  out  3  live lives.
- one, ten, hun  out  4 each  BCD digits of the live score.
- irq  out  1  vblank interrupt, level-sensitive.

## Operation
- Address map (writes go to staging):
  - 0–11: x, y, x1, y1 … x5, y5.
  - 12: state = wd[1:0], level = wd[4:2], result = wd[5].
  - 13: score = wd[7:0].
  - 14: nin_life = wd[2:0].
  - 15: control. wd[0]=1 clears irq; wd[1]=1 discards pending staging (dirty←0; staging is not reverted).
- Every staging write (addresses 0–14) sets dirty.
- Vblank-start pulse (vbs): one cycle, generated when vcount ≥ VACTIVE is true on this cycle and was false on the previous cycle (registered compare).
- On vbs:
  - frame_cnt (8 bits) increments, wrapping 255→0.
  - irq←1.
  - If dirty: every live register ← its staging value, dirty←0, and if score changed the BCD engine starts.
- BCD engine states:
  - IDLE: waits for a start.
  - SHIFT: runs SCORE_W double-dabble iterations. Each iteration adds 3 to any digit ≥5, then shifts left and brings in the next score bit, MSB first.
  - DONE: one, ten, hun update together in a single cycle, then the engine returns to IDLE.
  - one/ten/hun hold their previous values throughout SHIFT.
- Reads, address 15: readdata = {frame_cnt[7:0], 4'b0, bcd_busy, dirty, 1'b0, irq}.
- Reads, addresses 0–14: return the staging value, zero-extended.
- Reset values:
  - staging and live: x=300, y=200, x1=10, x2=70, x3=200, x4=300, x5=500, y1..y5=300.
  - state=0, level=0, result=0, score=0, nin_life=0.
  - one=ten=hun=0, irq=0, frame_cnt=0, dirty=0, readdata=0, BCD engine in IDLE.

## Timing
- Commit: live outputs change on the clock edge where vbs is high, which is 1 cycle after vcount first reaches VACTIVE.
- BCD latency: digits are valid SCORE_W+2 cycles after the commit edge (10 cycles with the default SCORE_W).
- Write on the vbs cycle: the commit copies the pre-write staging values. The write lands in staging and dirty stays 1, so it commits at the next vblank.
- Control wd[0] on the vbs cycle: the set wins, irq=1.
- Commit with a new score while BCD is busy: the engine restarts from iteration 0 with the new score. Old digits hold until the restarted run completes.
- Reset asserted mid-frame or mid-BCD: all registers return to reset values immediately. The vbs edge detector resets to "previous = 1" so no spurious vbs fires on release when vcount ≥ VACTIVE.
- readdata is registered. It is valid on the cycle after read&&chipselect and holds until the next read.

## Configuration
- VGA_SHADOW_IRQ_EN:
  - Defined: irq operates as described above.
  - Undefined: irq is tied to 0, the irq flop is not built, status bit 0 reads 0, and control wd[0] is ignored. The commit and frame_cnt logic are unchanged.

## Test plan
- Reset release with vcount=100: outputs x=300, y=200, x5=500, one/ten/hun=0, irq=0. No vbs on release.
- Write x←123 at vcount=200: live x stays 300 until vcount reaches 480. Live x=123 one cycle later; readback status shows dirty=0.
- Write score←255, then vblank: hun=2, ten=5, one=5 exactly 10 cycles after commit, with old digits held in between.
- Write y1←77 on the exact vbs cycle: live y1 unchanged this frame, y1=77 after the next vblank.
- Three vblanks, then control wd[0]=1: frame_cnt=3, irq 1→0. Build without VGA_SHADOW_IRQ_EN: irq stays 0 throughout.
- Commit score=9, then score=200 at the following vblank while busy is forced via back-to-back frames with a short VACTIVE: final digits read 2,0,0, with no intermediate garbage.
